traffic_injector: RTL and testbench
===================================

Name: traffic_injector

Overview:
- Source-side stage directly upstream of router input port 0 (local injection port).
- Holds a trace of packets, each tagged with an earliest-injection cycle and a destination.
- Releases one single-flit packet per staging slot onto a VC the router reports free via can_inject, using round-robin VC choice.
- Drives the 22-bit flit format of port 0's staging slot: [21] valid, [20:16] vc, [15:0] payload; payload[13:0] carries dest, the routing-table index.

Parameters:
- MAXVC, 8, width of can_inject and upper bound on numvcs.
- DEPTH, 16, trace-queue entries; must be a power of two.
- AW, 4, log2(DEPTH).

Ports:
- clk  input  1  clock; all state changes on posedge.
- rst  input  1  asynchronous active-high reset.
- wr_en  input  1  push trace entry this cycle.
- wr_data  input  32  trace entry: [15:0] inject cycle, [29:16] dest, [31:30] reserved (ignored).
- numvcs  input  6  number of active VCs, 1..MAXVC.
- stage_en  input  1  strobe: compute the next flit for router port 0.
- in_cycle  input  16  current simulation cycle.
- can_inject  input  MAXVC  per-VC "port-0 buffer empty" from router.
- out_flit  output  22  flit presented to router port 0 staging.
- full  output  1  queue full.
- done  output  1  queue empty and out_flit invalid.
- overflow  output  1  sticky: a push was dropped.
- inj_count  output  16  flits issued since reset.
- stall_count  output  16  stage_en strobes where head was ready but no VC was free.

Behaviour:
- Reset, asynchronous and immediate:
  - out_flit=0, full=0, done=1, overflow=0, inj_count=0, stall_count=0.
  - Queue pointers=0, rr_ptr=0.
  - Queue contents are don't-care.
  - Reset mid-operation discards all queued entries and any presented flit.
- Queue:
  - FIFO with AW+1-bit rd/wr pointers.
  - full when the pointers' MSBs differ and their low bits are equal.
  - empty when the pointers are equal.
  - full is combinational from the pointers.
- Push, when wr_en=1:
  - If not full, or a pop occurs in the same cycle: write the entry at wr_ptr and increment wr_ptr.
  - Otherwise drop the entry and set overflow=1. overflow stays set until rst.
  - Push and pop in the same cycle on an empty queue: the pushed entry is NOT eligible for that pop; the head is evaluated on pre-edge state.
- Head ready: queue non-empty and head[15:0] <= in_cycle, unsigned 16-bit compare, no wrap handling.
- On posedge with stage_en=1:
  - Candidate VCs: v in 0..numvcs-1 with can_inject[v]=1. VCs >= numvcs are never used.
  - Selection: the first candidate searching from rr_ptr upward, modulo numvcs.
  - If head ready and a candidate v exists:
    - out_flit <= {1'b1, v[4:0], 2'b00, head[29:16]}.
    - Pop the head.
    - rr_ptr <= (v+1) mod numvcs.
    - inj_count += 1, wrapping at 16 bits.
  - If head ready and no candidate: out_flit <= 0 and stall_count += 1, wrapping at 16 bits.
  - If head not ready: out_flit <= 0; no counter changes.
- stage_en=0: out_flit holds its value. Exactly one flit per strobe, at most.
- Timing contract with the controller:
  - stage_en is asserted one cycle before the router's LoadStaging edge.
  - out_flit is stable across that edge.
  - can_inject is sampled at the stage_en edge. It must already reflect the router's Phase0 of the previous slot; the injector keeps no per-VC shadow state.
- done = empty & ~out_flit[21], registered. It updates on the same edge as any queue or out_flit change.
- numvcs is treated as static between resets.
  - numvcs=0 or numvcs>MAXVC is illegal; the injector must then never issue.
  - If rr_ptr >= numvcs, it is treated as 0.
- Strict head-of-line order: a later entry is never issued before the head, even if the later entry is ready.

Test Plan:
- Reset then push {cyc=5,dest=0x12}, numvcs=4, can_inject=4'b1111:
  - Strobes at in_cycle=3 and 4 -> out_flit=0.
  - Strobe at in_cycle=5 -> out_flit=0x200012 (valid, vc0); inj_count=1; done=0.
  - Next strobe (queue empty) -> out_flit=0, done=1.
- Push 3 entries all cyc=0, can_inject=4'b1111, 3 strobes -> VCs issued 0,1,2 (round-robin).
- Same, but can_inject=4'b0101 -> VCs issued 0,2,0.
- Head ready, can_inject=0, 3 strobes -> out_flit=0 each time, stall_count=3, head retained; set can_inject[3]=1 -> next strobe issues on vc3.
- Push DEPTH+1 entries with no pop -> full=1 after 16 pushes, overflow=1, 17th entry lost. A push concurrent with a pop while full is accepted; overflow is unaffected.
- Assert rst during the cycle out_flit is valid, with queue non-empty -> out_flit=0, done=1 and full=0 immediately (before the next clk), and all counters=0.

Source files
------------

// File: rtl/traffic_injector.sv
// Purpose: trace-driven packet source feeding router input port 0 with single-flit packets.
// Latency: a ready head entry appears on out_flit at the stage_en edge; done/full track the same edge.
// Backpressure: no free VC (can_inject) holds the head and counts a stall; a push into a full queue is dropped and flagged.
module traffic_injector #(
    parameter int MAXVC = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [31:0]      wr_data,
    input  logic [5:0]       numvcs,
    input  logic             stage_en,
    input  logic [15:0]      in_cycle,
    input  logic [MAXVC-1:0] can_inject,
    output logic [21:0]      out_flit,
    output logic             full,
    output logic             done,
    output logic             overflow,
    output logic [15:0]      inj_count,
    output logic [15:0]      stall_count
);
    localparam int VW = (MAXVC > 1) ? $clog2(MAXVC) : 1;

    // Only the cycle and dest fields are kept; the reserved bits are not stored.
    logic [29:0] mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic [AW:0] wr_next, rd_next;
    logic [5:0]  rr_ptr, rr_start, sel_vc, rr_next;
    logic [6:0]  idx;
    logic [29:0] head;
    logic        empty, head_ready, legal, found, pop, push_ok;
    logic [21:0] flit_next;
    logic [1:0]  unused_rsvd;

    assign unused_rsvd = wr_data[31:30];

    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    assign head  = mem[rd_ptr[AW-1:0]];
    assign head_ready = !empty && (head[15:0] <= in_cycle);

    // An out-of-range VC count disables all candidates, so nothing is ever issued.
    assign legal    = (numvcs != 6'd0) && (int'(numvcs) <= MAXVC);
    assign rr_start = (rr_ptr >= numvcs) ? 6'd0 : rr_ptr;

    // Round-robin search: first free VC at or after rr_start, wrapping modulo numvcs.
    always_comb begin
        found  = 1'b0;
        sel_vc = 6'd0;
        idx    = 7'd0;
        for (int i = 0; i < MAXVC; i++) begin
            idx = {1'b0, rr_start} + 7'(i);
            if (idx >= {1'b0, numvcs}) idx = idx - {1'b0, numvcs};
            if (legal && !found && (7'(i) < {1'b0, numvcs}) && can_inject[idx[VW-1:0]]) begin
                found  = 1'b1;
                sel_vc = idx[5:0];
            end
        end
    end

    // Pop/push decisions and next-state values, all from pre-edge state.
    always_comb begin
        pop       = stage_en && head_ready && found;
        push_ok   = wr_en && (!full || pop);
        wr_next   = wr_ptr + (AW+1)'(push_ok);
        rd_next   = rd_ptr + (AW+1)'(pop);
        rr_next   = (sel_vc + 6'd1 == numvcs) ? 6'd0 : sel_vc + 6'd1;
        flit_next = out_flit;
        if (stage_en) begin
            flit_next = pop ? {1'b1, sel_vc[4:0], 2'b00, head[29:16]} : 22'd0;
        end
    end

    // Queue storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= wr_data[29:0];
    end

    // Pointers, output flit, status and counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            rr_ptr      <= 6'd0;
            out_flit    <= 22'd0;
            done        <= 1'b1;
            overflow    <= 1'b0;
            inj_count   <= 16'd0;
            stall_count <= 16'd0;
        end else begin
            wr_ptr   <= wr_next;
            rd_ptr   <= rd_next;
            out_flit <= flit_next;
            done     <= (wr_next == rd_next) && !flit_next[21];
            if (wr_en && !push_ok) overflow <= 1'b1;
            if (pop) begin
                rr_ptr    <= rr_next;
                inj_count <= inj_count + 16'd1;
            end
            if (stage_en && head_ready && !found) stall_count <= stall_count + 16'd1;
        end
    end
endmodule

// File: tb/tb_traffic_injector.sv
module tb_traffic_injector;
    localparam int MAXVC = 8;
    localparam int DEPTH = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             wr_en;
    logic [31:0]      wr_data;
    logic [5:0]       numvcs;
    logic             stage_en;
    logic [15:0]      in_cycle;
    logic [MAXVC-1:0] can_inject;
    logic [21:0]      out_flit;
    logic             full, done, overflow;
    logic [15:0]      inj_count, stall_count;

    traffic_injector #(.MAXVC(MAXVC), .DEPTH(DEPTH), .AW(4)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .numvcs(numvcs),
        .stage_en(stage_en), .in_cycle(in_cycle), .can_inject(can_inject),
        .out_flit(out_flit), .full(full), .done(done), .overflow(overflow),
        .inj_count(inj_count), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model state: trace queue, round-robin pointer, outputs.
    logic [29:0] mq[$];
    int          m_rr;
    logic [21:0] m_flit;
    bit          m_ovf;
    logic [15:0] m_inj, m_stall;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_rr = 0; m_flit = '0; m_ovf = 0; m_inj = '0; m_stall = '0;
    endtask

    // One clock edge of the spec's behaviour, evaluated on the current inputs.
    task automatic model_step();
        bit popped = 0;
        int nv = int'(numvcs);
        if (stage_en) begin
            if (mq.size() > 0 && mq[0][15:0] <= in_cycle) begin
                int pick = -1;
                if (nv >= 1 && nv <= MAXVC) begin
                    int start = (m_rr >= nv) ? 0 : m_rr;
                    for (int k = 0; k < nv; k++) begin
                        int v = (start + k) % nv;
                        if (pick < 0 && can_inject[v]) pick = v;
                    end
                end
                if (pick >= 0) begin
                    logic [4:0] v5 = 5'(pick);
                    m_flit = {1'b1, v5, 2'b00, mq[0][29:16]};
                    void'(mq.pop_front());
                    popped = 1;
                    m_rr = (pick + 1) % nv;
                    m_inj++;
                end else begin
                    m_flit = '0;
                    m_stall++;
                end
            end else begin
                m_flit = '0;
            end
        end
        if (wr_en) begin
            if (mq.size() < DEPTH || popped) mq.push_back(wr_data[29:0]);
            else m_ovf = 1;
        end
    endtask

    task automatic compare_all();
        check_val("out_flit", 32'(out_flit), 32'(m_flit));
        check_val("full", 32'(full), 32'(mq.size() == DEPTH));
        check_val("done", 32'(done), 32'(mq.size() == 0 && !m_flit[21]));
        check_val("overflow", 32'(overflow), 32'(m_ovf));
        check_val("inj_count", 32'(inj_count), 32'(m_inj));
        check_val("stall_count", 32'(stall_count), 32'(m_stall));
    endtask

    task automatic step(input bit we, input logic [31:0] wd, input bit se);
        wr_en = we; wr_data = wd; stage_en = se;
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        wr_en = 0; stage_en = 0; wr_data = '0;
        rst = 1;
        #1;
        model_reset();
        compare_all();
        @(posedge clk);
        #1;
        rst = 0;
    endtask

    function automatic logic [31:0] entry(input logic [13:0] dest, input logic [15:0] cyc);
        return {2'b00, dest, cyc};
    endfunction

    initial begin
        rst = 1; wr_en = 0; wr_data = '0; stage_en = 0;
        numvcs = 6'd4; in_cycle = '0; can_inject = 8'h0F;
        model_reset();

        // Single entry waits for its cycle, then issues on vc0.
        do_reset();
        step(1, entry(14'h12, 16'd5), 0);
        in_cycle = 16'd3; step(0, '0, 1);
        in_cycle = 16'd4; step(0, '0, 1);
        check_val("tp1_early", 32'(out_flit), 32'h0);
        in_cycle = 16'd5; step(0, '0, 1);
        check_val("tp1_flit", 32'(out_flit), 32'h200012);
        check_val("tp1_inj", 32'(inj_count), 32'd1);
        check_val("tp1_done_lo", 32'(done), 32'd0);
        step(0, '0, 1);
        check_val("tp1_drain", 32'(out_flit), 32'h0);
        check_val("tp1_done_hi", 32'(done), 32'd1);

        // Round-robin over all-free and sparse VC sets.
        for (int pass = 0; pass < 2; pass++) begin
            logic [4:0] exp_vc [3];
            do_reset();
            can_inject = (pass == 0) ? 8'h0F : 8'h05;
            in_cycle = 16'd10;
            exp_vc[0] = 5'd0;
            exp_vc[1] = (pass == 0) ? 5'd1 : 5'd2;
            exp_vc[2] = (pass == 0) ? 5'd2 : 5'd0;
            for (int i = 0; i < 3; i++) step(1, entry(14'(i + 1), 16'd0), 0);
            for (int i = 0; i < 3; i++) begin
                step(0, '0, 1);
                check_val("rr_vc", 32'(out_flit[20:16]), 32'(exp_vc[i]));
            end
        end

        // No free VC: stall three times, then issue on the one VC that frees up.
        do_reset();
        can_inject = 8'h00; in_cycle = 16'd10;
        step(1, entry(14'h2A, 16'd1), 0);
        for (int i = 0; i < 3; i++) step(0, '0, 1);
        check_val("stall_cnt", 32'(stall_count), 32'd3);
        check_val("stall_flit", 32'(out_flit), 32'h0);
        can_inject = 8'h08;
        step(0, '0, 1);
        check_val("stall_vc3", 32'(out_flit), {10'd0, 1'b1, 5'd3, 2'b00, 14'h2A});

        // Fill to DEPTH, push alongside a pop while full, then overflow.
        do_reset();
        can_inject = 8'h0F; in_cycle = 16'd10;
        for (int i = 0; i < DEPTH; i++) step(1, entry(14'(i + 16'h100), 16'd0), 0);
        check_val("fill_full", 32'(full), 32'd1);
        check_val("fill_ovf", 32'(overflow), 32'd0);
        step(1, entry(14'h3FF, 16'd0), 1);
        check_val("pushpop_full", 32'(full), 32'd1);
        check_val("pushpop_ovf", 32'(overflow), 32'd0);
        step(1, entry(14'h3EE, 16'd0), 0);
        check_val("drop_ovf", 32'(overflow), 32'd1);
        step(1, entry(14'h3DD, 16'd0), 1);
        check_val("pre_rst_vld", 32'(out_flit[21]), 32'd1);

        // Asynchronous reset while a flit is presented and the queue is full.
        wr_en = 0; stage_en = 0;
        rst = 1;
        #1;
        check_val("arst_flit", 32'(out_flit), 32'h0);
        check_val("arst_done", 32'(done), 32'd1);
        check_val("arst_full", 32'(full), 32'd0);
        check_val("arst_inj", 32'(inj_count), 32'd0);
        check_val("arst_stall", 32'(stall_count), 32'd0);
        check_val("arst_ovf", 32'(overflow), 32'd0);
        @(posedge clk); #1; rst = 0;
        model_reset();

        // Random traffic, including segments with illegal VC counts.
        for (int seg = 0; seg < 6; seg++) begin
            numvcs = (seg == 4) ? 6'd0 : (seg == 5) ? 6'd9 : 6'($urandom_range(1, MAXVC));
            do_reset();
            in_cycle = 16'd0;
            for (int c = 0; c < 400; c++) begin
                logic [15:0] cyc;
                cyc = in_cycle + 16'($urandom_range(0, 12));
                can_inject = 8'($urandom) | (($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom));
                if ($urandom_range(0, 4) == 0) can_inject = 8'h00;
                step($urandom_range(0, 2) != 0, {$urandom_range(0, 3) == 0 ? 2'b11 : 2'b00, 14'($urandom), cyc},
                     $urandom_range(0, 1) == 1);
                in_cycle = in_cycle + 16'd1;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
